// File: rtl/sm_accumulator.sv
// sm_accumulator: sign-magnitude accumulator for the neuron datapath.
// Sums up to N_TERMS sign-magnitude terms (or fewer, closed by in_last) taken
// over a valid/ready input, then presents the sum and a sticky overflow flag on
// a valid/ready output.
//
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   clear       - synchronous abort, drops any partial or pending result
//   in_valid / in_ready / in_data / in_last - input term stream
//   out_valid / out_ready / out_data / out_ovf - result stream
//   term_cnt    - terms accepted in the current accumulation
module sm_accumulator #(
  parameter int unsigned MAG_W    = 22,
  parameter int unsigned N_TERMS  = 8,
  parameter bit          SATURATE = 1'b1,
  localparam int unsigned CNT_W   = $clog2(N_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W:0]   in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W:0]   out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] term_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  state_e state_q, next_state;

  logic [MAG_W:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_d;
  logic             out_valid_d;

  logic             accept;
  logic             cnt_last;

  // Sign-magnitude adder operands and result
  logic [MAG_W-1:0] a_mag, b_mag, add_mag;
  logic             a_neg, b_neg, add_neg, add_ovf;
  logic [MAG_W:0]   sum_full;

  assign accept   = in_valid && in_ready;
  assign cnt_last = (cnt_q == CNT_W'(N_TERMS - 1));

  // Combinational sign-magnitude add of the incoming term onto the accumulator
  always_comb begin
    a_mag    = acc_q[MAG_W-1:0];
    a_neg    = acc_q[MAG_W];
    b_mag    = in_data[MAG_W-1:0];
    // negative zero behaves as +0
    b_neg    = in_data[MAG_W] && (b_mag != '0);
    sum_full = {1'b0, a_mag} + {1'b0, b_mag};
    add_mag  = '0;
    add_neg  = 1'b0;
    add_ovf  = 1'b0;
    if (a_neg == b_neg) begin
      add_ovf = sum_full[MAG_W];
      add_mag = (add_ovf && SATURATE) ? '1 : sum_full[MAG_W-1:0];
      add_neg = a_neg;
    end else if (a_mag >= b_mag) begin
      add_mag = a_mag - b_mag;
      add_neg = a_neg;
    end else begin
      add_mag = b_mag - a_mag;
      add_neg = b_neg;
    end
    // zero always carries a positive sign
    if (add_mag == '0) begin
      add_neg = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // Next-state logic; clear overrides everything
  always_comb begin
    next_state = state_q;
    if (clear) begin
      next_state = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_ACC: begin
          if (accept) begin
            next_state = (in_last || cnt_last) ? S_OUT : S_ACC;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            next_state = S_IDLE;
          end
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  // Datapath and handshake next values
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    in_ready_d  = (next_state != S_OUT);
    out_valid_d = (next_state == S_OUT);
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_ACC: begin
          if (accept) begin
            acc_d = {add_neg, add_mag};
            cnt_d = cnt_q + CNT_W'(1);
            ovf_d = ovf_q | add_ovf;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
          end
        end
        default: begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end
      endcase
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  assign out_data = acc_q;
  assign out_ovf  = ovf_q;
  assign term_cnt = cnt_q;

endmodule

// File: tb/tb_sm_accumulator.sv
// Testbench for sm_accumulator: two instances (saturating and wrapping) share
// the stimulus; a signed-integer reference model predicts each result and a
// monitor compares results as they are handed off.
module tb_sm_accumulator;

  localparam int unsigned MAG_W   = 22;
  localparam int unsigned N_TERMS = 4;
  localparam int unsigned CNT_W   = $clog2(N_TERMS + 1);
  localparam longint      MAXM    = (64'sd1 <<< MAG_W) - 1;
  localparam longint      MODV    = (64'sd1 <<< MAG_W);

  typedef struct {
    logic [MAG_W:0] data;
    logic           ovf;
    int             cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, clear, in_valid, in_last, out_ready;
  logic [MAG_W:0] in_data;

  logic             in_ready_s, out_valid_s, out_ovf_s;
  logic [MAG_W:0]   out_data_s;
  logic [CNT_W-1:0] term_cnt_s;
  logic             in_ready_w, out_valid_w, out_ovf_w;
  logic [MAG_W:0]   out_data_w;
  logic [CNT_W-1:0] term_cnt_w;

  int vectors = 0;
  int miscompares = 0;
  bit rand_ready = 1'b0;

  exp_t qs[$];
  exp_t qw[$];
  exp_t ms, mw;

  // Reference model: index 0 = saturating, 1 = wrapping
  longint macc [2];
  bit     movf [2];
  int     mcnt;
  logic [MAG_W:0] last_exp_s;

  always #5 clk = ~clk;

  sm_accumulator #(.MAG_W(MAG_W), .N_TERMS(N_TERMS), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .out_ovf(out_ovf_s), .term_cnt(term_cnt_s)
  );

  sm_accumulator #(.MAG_W(MAG_W), .N_TERMS(N_TERMS), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
    .out_ovf(out_ovf_w), .term_cnt(term_cnt_w)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint dec(input logic [MAG_W:0] d);
    longint m;
    m = longint'(d[MAG_W-1:0]);
    return d[MAG_W] ? -m : m;
  endfunction

  function automatic logic [MAG_W:0] enc(input longint v);
    longint a;
    a = (v < 0) ? -v : v;
    return {(v < 0), MAG_W'(a)};
  endfunction

  task automatic model_reset();
    mcnt = 0;
    for (int m = 0; m < 2; m++) begin
      macc[m] = 0;
      movf[m] = 1'b0;
    end
  endtask

  // Signed sum; on magnitude overflow either clamp or drop the 2^MAG_W carry
  task automatic model_add(input logic [MAG_W:0] d);
    longint s;
    for (int m = 0; m < 2; m++) begin
      s = macc[m] + dec(d);
      if (s > MAXM || s < -MAXM) begin
        movf[m] = 1'b1;
        if (m == 0) s = (s > 0) ? MAXM : -MAXM;
        else        s = (s > 0) ? s - MODV : s + MODV;
      end
      macc[m] = s;
    end
  endtask

  // Present one term (called at a negedge); returns at the negedge after accept
  task automatic send(input logic [MAG_W:0] d, input logic last);
    bit rdy;
    bit closing;
    int n;
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    forever begin
      rdy = in_ready_s && in_ready_w;
      @(posedge clk);
      if (rdy) break;
      @(negedge clk);
      n++;
      if (n > 50) begin
        chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    model_add(d);
    mcnt++;
    closing = last || (mcnt == N_TERMS);
    if (closing) begin
      e.data = enc(macc[0]); e.ovf = movf[0]; e.cnt = mcnt;
      qs.push_back(e);
      last_exp_s = e.data;
      e.data = enc(macc[1]); e.ovf = movf[1];
      qw.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("out_valid_latency", longint'(out_valid_s), longint'(closing));
    chk("term_cnt_after_accept", longint'(term_cnt_s), longint'(mcnt));
    if (closing) model_reset();
  endtask

  task automatic drain();
    int n = 0;
    while ((qs.size() != 0 || qw.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  // Result monitor: compare each handed-off result against the queued model value
  always @(negedge clk) begin
    #1;
    if (rst_n && out_valid_s && out_ready) begin
      if (qs.size() == 0) chk("sat_unexpected_result", 1, 0);
      else begin
        ms = qs.pop_front();
        chk("sat_out_data", longint'(out_data_s), longint'(ms.data));
        chk("sat_out_ovf", longint'(out_ovf_s), longint'(ms.ovf));
        chk("sat_term_cnt", longint'(term_cnt_s), longint'(ms.cnt));
      end
    end
    if (rst_n && out_valid_w && out_ready) begin
      if (qw.size() == 0) chk("wrap_unexpected_result", 1, 0);
      else begin
        mw = qw.pop_front();
        chk("wrap_out_data", longint'(out_data_w), longint'(mw.data));
        chk("wrap_out_ovf", longint'(out_ovf_w), longint'(mw.ovf));
        chk("wrap_term_cnt", longint'(term_cnt_w), longint'(mw.cnt));
      end
    end
  end

  // Random downstream backpressure
  always @(negedge clk) begin
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MAG_W:0] d;
    longint mag;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = '0; out_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_out_valid", longint'(out_valid_s), 0);
    chk("reset_term_cnt", longint'(term_cnt_s), 0);
    chk("reset_out_data", longint'(out_data_s), 0);
    chk("reset_out_ovf", longint'(out_ovf_s), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", longint'(in_ready_s), 1);

    // Count-terminated, mixed signs
    send(23'h00000A, 0); send(23'h000014, 0); send(23'h400005, 0); send(23'h000003, 0);
    // Cancellation and negative-zero input
    send(23'h000007, 0); send(23'h400007, 1);
    send(23'h400000, 0); send(23'h000003, 1);
    // Sign follows the larger magnitude
    send(23'h000003, 0); send(23'h40000A, 1);
    // Overflow, positive and negative
    send(23'h3FFFFF, 0); send(23'h000001, 1);
    send(23'h7FFFFF, 0); send(23'h400002, 0); send(23'h000005, 1);
    drain();

    // Backpressure: result held, held term not absorbed
    out_ready = 1'b0;
    send(23'h000009, 0); send(23'h000001, 1);
    in_valid = 1'b1; in_data = 23'h000055; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", longint'(in_ready_s), 0);
      chk("bp_out_valid", longint'(out_valid_s), 1);
      chk("bp_out_data", longint'(out_data_s), longint'(last_exp_s));
      chk("bp_term_cnt", longint'(term_cnt_s), 2);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(23'h000055, 1);
    drain();

    // Clear mid-accumulation; term in the clear cycle is ignored
    send(23'h000004, 0); send(23'h000006, 0);
    clear = 1'b1; in_valid = 1'b1; in_data = 23'h000077; in_last = 1'b1;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    model_reset();
    chk("clear_term_cnt", longint'(term_cnt_s), 0);
    chk("clear_out_data", longint'(out_data_s), 0);
    chk("clear_out_valid", longint'(out_valid_s), 0);
    send(23'h000001, 1);
    drain();

    // Clear while a result is pending drops it
    out_ready = 1'b0;
    send(23'h000008, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_out_drop", longint'(out_valid_s), 0);
    void'(qs.pop_back());
    void'(qw.pop_back());
    out_ready = 1'b1;
    @(negedge clk);

    // Asynchronous reset mid-accumulation
    send(23'h000005, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", longint'(out_valid_s), 0);
    chk("async_rst_term_cnt", longint'(term_cnt_s), 0);
    chk("async_rst_out_data", longint'(out_data_s), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(23'h000002, 1);
    drain();

    // Randomized terms with random backpressure and gaps
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: mag = longint'($urandom_range(0, 20));
        1: mag = MAXM - longint'($urandom_range(0, 15));
        2: mag = longint'($urandom) & MAXM;
        default: mag = 0;
      endcase
      d = {1'($urandom_range(0, 1)), MAG_W'(mag)};
      send(d, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end
    rand_ready = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    if (mcnt != 0) send(23'h000000, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sm_accumulator.md
Name: sm_accumulator

Overview:
- Parametrised sign-magnitude accumulator for the neuron datapath.
- Takes a stream of sign-magnitude terms over a valid/ready handshake and sums up to N_TERMS of them (or fewer, ended by in_last).
- Presents the saturated sum with an overflow flag on a valid/ready output.
- Feeds the neuron activation stage; replaces chains of single-cycle combinational adders.

Parameters:
- MAG_W, 22, magnitude width; data words are MAG_W+1 bits, sign in MSB (1 = negative).
- N_TERMS, 8, maximum terms per accumulation (>=1); the term counter terminates automatically at this count.
- SATURATE, 1, 1 = clamp magnitude at 2^MAG_W-1 on overflow; 0 = drop carry (wrap); out_ovf is flagged in both modes.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort: return to IDLE and discard the partial sum.
- in_valid  in  1  input term valid.
- in_ready  out  1  block can accept a term.
- in_data  in  MAG_W+1  sign-magnitude term.
- in_last  in  1  qualifies in_data; this term closes the accumulation.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  MAG_W+1  accumulated sum, sign-magnitude.
- out_ovf  out  1  sticky: at least one overflow occurred in this accumulation.
- term_cnt  out  clog2(N_TERMS+1)  terms accepted in the current accumulation.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; accumulator, term_cnt and out_ovf = 0; out_valid=0; out_data=0; in_ready=1 after release.
- States:
  - IDLE: accumulator and term count are zero; in_ready=1.
  - ACC: at least one term accepted; in_ready=1.
  - OUT: out_valid=1; in_ready=0.
- Accept: in_valid && in_ready at a rising edge.
  - acc <= acc (+) in_data; term_cnt increments.
  - Transition to OUT if in_last=1 or term_cnt reaches N_TERMS with this term; otherwise to ACC.
- Latency: out_valid asserts the cycle after the closing term is accepted. Throughput is one term per cycle while in IDLE/ACC.
- OUT:
  - out_data and out_ovf are held stable while out_ready=0.
  - On out_valid && out_ready: go to IDLE with acc, term_cnt and ovf cleared.
  - in_ready stays 0 in the handshake cycle; the next accumulation starts the following cycle.
- Sign-magnitude add (one term per cycle, combinational within that cycle):
  - Same signs: add magnitudes with MAG_W+1-bit carry; sign kept.
  - Different signs: subtract the smaller magnitude from the larger; the result takes the sign of the larger magnitude.
  - Equal magnitudes with different signs: result is +0.
  - Negative zero input (sign=1, mag=0) is treated as +0.
  - A zero result always carries sign 0.
- Overflow (carry out of the magnitude):
  - out_ovf is set sticky.
  - SATURATE=1: magnitude clamps to 2^MAG_W-1 and keeps its sign; later terms operate on the clamped value.
  - SATURATE=0: carry is discarded.
- clear:
  - Highest synchronous priority, effective in any state, including OUT (the result is dropped, out_valid falls next cycle).
  - A term presented in the same cycle as clear is not accepted.
- in_last is ignored unless accepted.
- in_valid while in_ready=0 has no effect; the upstream must hold the term.
- N_TERMS=1: every accepted term goes straight to OUT.
- Reset mid-operation: immediate return to reset values; no partial result is emitted.

Test Plan:
- MAG_W=22, N_TERMS=4, SATURATE=1. Send +10, +20, -5 (0x400005), +3 back-to-back, in_last=0 -> out_valid one cycle after 4th accept, out_data=0x00001C, out_ovf=0, term_cnt=4.
- Send +7, then -7 (0x400007) with in_last -> out_data=0x000000 (positive zero), out_valid after 2 terms. Send 0x400000, +3 with in_last -> 0x000003.
- Send +3, then -10 (0x40000A) with in_last -> out_data=0x400007.
- Send 0x3FFFFF, then +1 with in_last -> out_data=0x3FFFFF, out_ovf=1. Send 0x7FFFFF, 0x400002, +5 with in_last -> 0x7FFFFA, out_ovf=1. With SATURATE=0, 0x3FFFFF + 1 -> 0x000000, out_ovf=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in OUT while in_valid=1 -> out_data stable, in_ready=0, no term absorbed.
  - Raise out_ready -> IDLE; the held term is accepted next cycle into a zeroed accumulator.
- Abort and reset:
  - clear after 2 terms (+4, +6), then +1 with in_last -> out_data=0x000001.
  - Pull rst_n low asynchronously mid-accumulation -> out_valid=0, term_cnt=0 without a clock edge.
  - After release, +2 with in_last -> 0x000002.
